// File: rtl/fpro_io_bridge.sv
// fpro_io_bridge: converts the CPU strobe/ready IO bus into the single-cycle
// FPro MMIO bus. Each accepted request drives at most one FPro cycle and
// returns a one-cycle io_ready pulse; out-of-window accesses skip the FPro bus.
// Optional feature macro: FPRO_BRIDGE_BE_CHK_EN. When it is defined, FPro
// writes whose byte enables are not a full word (4'hF) are suppressed, but the
// request still completes.
module fpro_io_bridge #(
  parameter logic [31:0] BRG_BASE    = 32'hC000_0000,
  parameter int          WIN_SEL_BIT = 23
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_addr_strobe,
  input  logic        io_read_strobe,
  input  logic        io_write_strobe,
  input  logic [31:0] io_address,
  input  logic [3:0]  io_byte_enable,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        io_ready,
  output logic        fp_mmio_cs,
  output logic        fp_wr,
  output logic        fp_rd,
  output logic [20:0] fp_addr,
  output logic [31:0] fp_wr_data,
  input  logic [31:0] fp_rd_data
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t r_state;
  logic   r_is_write;

  logic w_accept;
  logic w_hit;
  logic w_wr_ok;
  logic w_unused;

  // A request is taken only when exactly one of read/write is asserted.
  assign w_accept = io_addr_strobe && (io_read_strobe ^ io_write_strobe);

  // Window hit: top byte matches the base and the video-region bit is clear.
  assign w_hit = (io_address[31:24] == BRG_BASE[31:24]) &&
                 !io_address[WIN_SEL_BIT];

`ifdef FPRO_BRIDGE_BE_CHK_EN
  // Only full-word writes may reach the word-only FPro bus.
  assign w_wr_ok  = (io_byte_enable == 4'hF);
  assign w_unused = ^io_address[1:0];
`else
  // Byte enables are ignored; every write hit becomes a full-word write.
  assign w_wr_ok  = 1'b1;
  assign w_unused = ^{io_address[1:0], io_byte_enable};
`endif

  // Request FSM: every output is registered and set on the transition into
  // the state in which it must be visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_is_write   <= 1'b0;
      io_read_data <= 32'h0;
      io_ready     <= 1'b0;
      fp_mmio_cs   <= 1'b0;
      fp_wr        <= 1'b0;
      fp_rd        <= 1'b0;
      fp_addr      <= 21'h0;
      fp_wr_data   <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          io_ready <= 1'b0;
          if (w_accept) begin
            r_is_write <= io_write_strobe;
            if (w_hit) begin
              fp_mmio_cs <= 1'b1;
              fp_addr    <= io_address[22:2];
              fp_wr_data <= io_write_data;
              fp_wr      <= io_write_strobe && w_wr_ok;
              fp_rd      <= io_read_strobe;
              r_state    <= ACCESS;
            end else begin
              io_ready     <= 1'b1;
              io_read_data <= 32'h0;
              r_state      <= RESP;
            end
          end
        end
        ACCESS: begin
          fp_mmio_cs   <= 1'b0;
          fp_wr        <= 1'b0;
          fp_rd        <= 1'b0;
          io_ready     <= 1'b1;
          io_read_data <= r_is_write ? 32'h0 : fp_rd_data;
          r_state      <= RESP;
        end
        RESP: begin
          io_ready <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
